// File: rtl/ucca_pkg.sv
// Shared state encoding and violation cause codes for the multi-region UCC monitor.
package ucca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_SUSPENDED = 2'd2,
    ST_VIOL      = 2'd3
  } ucca_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_ENTRY = 3'd1,
    CAUSE_EXIT  = 3'd2,
    CAUSE_STACK = 3'd3,
    CAUSE_IRQ   = 3'd4,
    CAUSE_NEST  = 3'd5
  } ucca_cause_e;

  // Wide enough for a hold count of up to 15 cycles.
  localparam int HOLD_W = 4;

endpackage

// File: rtl/ucca_region_match.sv
// Bounds comparison for one region: raw validity, inclusive range hit and entry-point hit.
module ucca_region_match #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] min_i,
  input  logic [ADDR_W-1:0] max_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic              in_range_o,
  output logic              at_entry_o
);

  // in_range/at_entry are pure address compares; the top qualifies them with valid.
  assign valid_o    = en_i && (min_i <= max_i);
  assign in_range_o = (pc_i >= min_i) && (pc_i <= max_i);
  assign at_entry_o = (pc_i == min_i);

endmodule

// File: rtl/ucca_multi_region_monitor.sv
// Multi-region UCC monitor: enforces entry/exit points, stack-write bounds and interrupt
// policy for each configured region, pulsing `reset` for RESET_HOLD cycles on a violation.
module ucca_multi_region_monitor
  import ucca_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 16,
  parameter int IRQ_MODE    = 0,
  parameter int RESET_HOLD  = 4,
  localparam int AR_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                          clk,
  input  logic                          system_reset_n,
  input  logic [ADDR_W-1:0]             pc,
  input  logic                          inst_changed,
  input  logic                          data_en,
  input  logic                          data_wr,
  input  logic [ADDR_W-1:0]             data_addr,
  input  logic [ADDR_W-1:0]             stack_pointer,
  input  logic                          irq_jmp,
  input  logic [NUM_REGIONS*ADDR_W-1:0] ucc_min,
  input  logic [NUM_REGIONS*ADDR_W-1:0] ucc_max,
  input  logic [NUM_REGIONS-1:0]        region_en,
  output logic                          reset,
  output logic                          in_region,
  output logic [AR_W-1:0]               active_region,
  output logic [ADDR_W-1:0]             base_pointer,
  output logic [2:0]                    viol_cause,
  output ucca_state_e                   dbg_state
);

  logic [NUM_REGIONS-1:0] valid_v, in_range_v, at_entry_v;
  logic [NUM_REGIONS-1:0] hit_v, entry_v;
  logic [ADDR_W-1:0]      max_arr [NUM_REGIONS];

  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_region
    ucca_region_match #(.ADDR_W(ADDR_W)) u_match (
      .min_i      (ucc_min[k*ADDR_W +: ADDR_W]),
      .max_i      (ucc_max[k*ADDR_W +: ADDR_W]),
      .en_i       (region_en[k]),
      .pc_i       (pc),
      .valid_o    (valid_v[k]),
      .in_range_o (in_range_v[k]),
      .at_entry_o (at_entry_v[k])
    );
    assign max_arr[k] = ucc_max[k*ADDR_W +: ADDR_W];
  end

  assign hit_v   = in_range_v & valid_v;
  assign entry_v = at_entry_v & valid_v;

  // Overlapping regions resolve to the lowest index.
  logic            hit_any;
  logic [AR_W-1:0] hit_idx;

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (hit_v[k]) begin
        hit_any = 1'b1;
        hit_idx = AR_W'(k);
      end
    end
  end

  ucca_state_e       state_q, state_d;
  logic [AR_W-1:0]   ar_q, ar_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        cause_q, cause_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              reset_q, reset_d;
  logic [ADDR_W-1:0] prev_pc_q;

  logic        viol;
  ucca_cause_e viol_code;
  logic        own_in;
  logic        stack_ev;

  always_comb begin
    state_d   = state_q;
    ar_d      = ar_q;
    base_d    = base_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    reset_d   = 1'b0;
    viol      = 1'b0;
    viol_code = CAUSE_NONE;
    own_in    = hit_v[ar_q];
    stack_ev  = data_en && data_wr && (data_addr >= base_q);

    // The if/else chain in ACTIVE encodes the priority STACK > IRQ > EXIT.
    unique case (state_q)
      ST_IDLE: begin
        if (inst_changed && hit_any) begin
          if (entry_v[hit_idx]) begin
            state_d = ST_ACTIVE;
            ar_d    = hit_idx;
            base_d  = stack_pointer;
          end else begin
            viol      = 1'b1;
            viol_code = CAUSE_ENTRY;
          end
        end
      end
      ST_ACTIVE: begin
        if (stack_ev) begin
          viol      = 1'b1;
          viol_code = CAUSE_STACK;
        end else if (irq_jmp) begin
          if (IRQ_MODE == 0) begin
            viol      = 1'b1;
            viol_code = CAUSE_IRQ;
          end else begin
            state_d = ST_SUSPENDED;
          end
        end else if (inst_changed && !own_in) begin
          if (prev_pc_q == max_arr[ar_q]) begin
            if (hit_any && entry_v[hit_idx]) begin
              ar_d   = hit_idx;
              base_d = stack_pointer;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            viol      = 1'b1;
            viol_code = CAUSE_EXIT;
          end
        end
      end
      ST_SUSPENDED: begin
        if (inst_changed) begin
          if (own_in) begin
            state_d = ST_ACTIVE;
          end else if (hit_any) begin
            viol      = 1'b1;
            viol_code = CAUSE_NEST;
          end
        end
      end
      ST_VIOL: begin
        if (cnt_q > HOLD_W'(1)) begin
          cnt_d   = cnt_q - HOLD_W'(1);
          reset_d = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
    endcase

    if (viol) begin
      state_d = ST_VIOL;
      cnt_d   = HOLD_W'(RESET_HOLD);
      reset_d = 1'b1;
      cause_d = viol_code;
      base_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q   <= ST_IDLE;
      ar_q      <= '0;
      base_q    <= '0;
      cause_q   <= '0;
      cnt_q     <= '0;
      reset_q   <= 1'b0;
      prev_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      ar_q      <= ar_d;
      base_q    <= base_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      reset_q   <= reset_d;
      if (inst_changed) begin
        prev_pc_q <= pc;
      end
    end
  end

  assign reset         = reset_q;
  assign in_region     = (state_q == ST_ACTIVE) || (state_q == ST_SUSPENDED);
  assign active_region = ar_q;
  assign base_pointer  = base_q;
  assign viol_cause    = cause_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ucca_multi_region_monitor.sv
// Scoreboard bench: two monitors (IRQ_MODE 0 and 1) share stimulus; each step pushes the
// expected {state, reset, in_region, active_region, base_pointer, viol_cause} per instance.
module tb_ucca_multi_region_monitor;
  import ucca_pkg::*;

  localparam int NR = 4;
  localparam int AW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    pc = '0, data_addr = '0, sp = 16'h0400;
  logic             inst_changed = 1'b0, data_en = 1'b0, data_wr = 1'b0, irq_jmp = 1'b0;
  logic [NR*AW-1:0] ucc_min = {16'hF800, 16'hD100, 16'hE200, 16'hE000};
  logic [NR*AW-1:0] ucc_max = {16'hF8FF, 16'hD000, 16'hE2FF, 16'hE0FF};
  logic [NR-1:0]    region_en = 4'b0111;

  logic        rs0, ir0, rs1, ir1;
  logic [1:0]  ar0, ar1;
  logic [AW-1:0] bp0, bp1;
  logic [2:0]  vc0, vc1;
  ucca_state_e st0, st1;

  ucca_multi_region_monitor #(.NUM_REGIONS(NR), .ADDR_W(AW), .IRQ_MODE(0), .RESET_HOLD(4)) dut0 (
    .clk(clk), .system_reset_n(rst_n), .pc(pc), .inst_changed(inst_changed),
    .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr), .stack_pointer(sp),
    .irq_jmp(irq_jmp), .ucc_min(ucc_min), .ucc_max(ucc_max), .region_en(region_en),
    .reset(rs0), .in_region(ir0), .active_region(ar0), .base_pointer(bp0),
    .viol_cause(vc0), .dbg_state(st0)
  );

  ucca_multi_region_monitor #(.NUM_REGIONS(NR), .ADDR_W(AW), .IRQ_MODE(1), .RESET_HOLD(4)) dut1 (
    .clk(clk), .system_reset_n(rst_n), .pc(pc), .inst_changed(inst_changed),
    .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr), .stack_pointer(sp),
    .irq_jmp(irq_jmp), .ucc_min(ucc_min), .ucc_max(ucc_max), .region_en(region_en),
    .reset(rs1), .in_region(ir1), .active_region(ar1), .base_pointer(bp1),
    .viol_cause(vc1), .dbg_state(st1)
  );

  // scoreboard
  logic [24:0] exp0_q[$];
  logic [24:0] exp1_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [24:0] ev(input logic [1:0] st, input logic r, input logic inr,
                                     input logic [1:0] ar, input logic [15:0] bp,
                                     input logic [2:0] c);
    return {st, r, inr, ar, bp, c};
  endfunction

  task automatic check_eq(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d rst=%0b in=%0b ar=%0d bp=%h cause=%0d, expected st=%0d rst=%0b in=%0b ar=%0d bp=%h cause=%0d",
               tag, obs[24:23], obs[22], obs[21], obs[20:19], obs[18:3], obs[2:0],
               exp[24:23], exp[22], exp[21], exp[20:19], exp[18:3], exp[2:0]);
    end
  endtask

  // driver tasks
  task automatic set_pc(input logic [AW-1:0] a);
    pc = a;
    inst_changed = 1'b1;
  endtask

  task automatic do_write(input logic [AW-1:0] a);
    data_en = 1'b1;
    data_wr = 1'b1;
    data_addr = a;
  endtask

  task automatic tick(input string tag, input logic [24:0] e0, input logic [24:0] e1);
    logic [24:0] x0, x1;
    exp0_q.push_back(e0);
    exp1_q.push_back(e1);
    @(posedge clk);
    #1;
    x0 = exp0_q.pop_front();
    x1 = exp1_q.pop_front();
    check_eq({tag, "/irq0"}, {st0, rs0, ir0, ar0, bp0, vc0}, x0);
    check_eq({tag, "/irq1"}, {st1, rs1, ir1, ar1, bp1, vc1}, x1);
    inst_changed = 1'b0;
    data_en = 1'b0;
    data_wr = 1'b0;
    irq_jmp = 1'b0;
  endtask

  task automatic tick2(input string tag, input logic [24:0] e);
    tick(tag, e, e);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "/irq0"}, {st0, rs0, ir0, ar0, bp0, vc0}, ev(ST_IDLE, 0, 0, 0, 16'h0, 0));
    check_eq({tag, "/irq1"}, {st1, rs1, ir1, ar1, bp1, vc1}, ev(ST_IDLE, 0, 0, 0, 16'h0, 0));
  endtask

  initial begin
    #1;
    check_reset_state("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Disabled region and inverted-bounds region never match.
    set_pc(16'hF800); tick2("dis_region", ev(ST_IDLE, 0, 0, 0, 16'h0, 0));
    set_pc(16'hD080); tick2("inv_region", ev(ST_IDLE, 0, 0, 0, 16'h0, 0));

    // Legal entry, in-bounds traffic, legal exit.
    sp = 16'h0400; set_pc(16'hE000); tick2("entry0", ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 0));
    sp = 16'h0200; set_pc(16'hE001); tick2("step0", ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 0));
    do_write(16'h03FF); tick2("wr_below", ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 0));
    data_en = 1'b1; data_addr = 16'h0402; tick2("rd_above", ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 0));
    set_pc(16'hE0FF); tick2("at_max", ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 0));
    set_pc(16'hC000); tick2("legal_exit", ev(ST_IDLE, 0, 0, 0, 16'h0400, 0));

    // Mid-region entry: 4-cycle reset; an event during VIOL is ignored.
    set_pc(16'hE010); tick2("entry_viol", ev(ST_VIOL, 1, 0, 0, 16'h0, 1));
    set_pc(16'hE010); tick2("viol_ignore", ev(ST_VIOL, 1, 0, 0, 16'h0, 1));
    for (int i = 0; i < 2; i++) tick2("entry_hold", ev(ST_VIOL, 1, 0, 0, 16'h0, 1));
    tick2("entry_done", ev(ST_IDLE, 0, 0, 0, 16'h0, 1));

    // Illegal exit from region 1.
    sp = 16'h0500; set_pc(16'hE200); tick2("entry1", ev(ST_ACTIVE, 0, 1, 1, 16'h0500, 1));
    set_pc(16'hE300); tick2("exit_viol", ev(ST_VIOL, 1, 0, 1, 16'h0, 2));
    for (int i = 0; i < 3; i++) tick2("exit_hold", ev(ST_VIOL, 1, 0, 1, 16'h0, 2));
    tick2("exit_done", ev(ST_IDLE, 0, 0, 1, 16'h0, 2));

    // Stack write above base.
    sp = 16'h0400; set_pc(16'hE000); tick2("entry_s", ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 2));
    do_write(16'h0402); tick2("stack_viol", ev(ST_VIOL, 1, 0, 0, 16'h0, 3));
    for (int i = 0; i < 3; i++) tick2("stack_hold", ev(ST_VIOL, 1, 0, 0, 16'h0, 3));
    tick2("stack_done", ev(ST_IDLE, 0, 0, 0, 16'h0, 3));

    // Interrupt: violation in mode 0, suspend/resume in mode 1.
    set_pc(16'hE000); tick2("entry_i", ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 3));
    irq_jmp = 1'b1; set_pc(16'hF800);
    tick("irq", ev(ST_VIOL, 1, 0, 0, 16'h0, 4), ev(ST_SUSPENDED, 0, 1, 0, 16'h0400, 3));
    sp = 16'h0300; set_pc(16'hF804); do_write(16'h0500);
    tick("isr_write", ev(ST_VIOL, 1, 0, 0, 16'h0, 4), ev(ST_SUSPENDED, 0, 1, 0, 16'h0400, 3));
    set_pc(16'hE020);
    tick("resume", ev(ST_VIOL, 1, 0, 0, 16'h0, 4), ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 3));
    tick("irq_hold", ev(ST_VIOL, 1, 0, 0, 16'h0, 4), ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 3));
    tick("irq_done", ev(ST_IDLE, 0, 0, 0, 16'h0, 4), ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 3));
    do_write(16'h0402);
    tick("resumed_stack", ev(ST_IDLE, 0, 0, 0, 16'h0, 4), ev(ST_VIOL, 1, 0, 0, 16'h0, 3));
    for (int i = 0; i < 3; i++)
      tick("rs_hold", ev(ST_IDLE, 0, 0, 0, 16'h0, 4), ev(ST_VIOL, 1, 0, 0, 16'h0, 3));
    tick("rs_done", ev(ST_IDLE, 0, 0, 0, 16'h0, 4), ev(ST_IDLE, 0, 0, 0, 16'h0, 3));

    // Nesting into another region while suspended.
    sp = 16'h0400; set_pc(16'hE000);
    tick("entry_n", ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 4), ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 3));
    irq_jmp = 1'b1; set_pc(16'hF800);
    tick("irq_n", ev(ST_VIOL, 1, 0, 0, 16'h0, 4), ev(ST_SUSPENDED, 0, 1, 0, 16'h0400, 3));
    set_pc(16'hE200);
    tick("nest", ev(ST_VIOL, 1, 0, 0, 16'h0, 4), ev(ST_VIOL, 1, 0, 0, 16'h0, 5));
    for (int i = 0; i < 2; i++)
      tick("nest_hold", ev(ST_VIOL, 1, 0, 0, 16'h0, 4), ev(ST_VIOL, 1, 0, 0, 16'h0, 5));
    tick("nest_hold3", ev(ST_IDLE, 0, 0, 0, 16'h0, 4), ev(ST_VIOL, 1, 0, 0, 16'h0, 5));
    tick("nest_done", ev(ST_IDLE, 0, 0, 0, 16'h0, 4), ev(ST_IDLE, 0, 0, 0, 16'h0, 5));

    // Stack write and illegal exit together: STACK wins.
    set_pc(16'hE000);
    tick("entry_p", ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 4), ev(ST_ACTIVE, 0, 1, 0, 16'h0400, 5));
    set_pc(16'hC000); do_write(16'h0410);
    tick2("prio_stack", ev(ST_VIOL, 1, 0, 0, 16'h0, 3));
    tick2("prio_hold", ev(ST_VIOL, 1, 0, 0, 16'h0, 3));

    // Asynchronous reset mid-hold, then a fresh entry.
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    #2;
    rst_n = 1'b1;
    sp = 16'h0600; set_pc(16'hE200); tick2("post_rst_entry", ev(ST_ACTIVE, 0, 1, 1, 16'h0600, 0));
    set_pc(16'hE2FF); tick2("at_max1", ev(ST_ACTIVE, 0, 1, 1, 16'h0600, 0));
    sp = 16'h0700; set_pc(16'hE000); tick2("exit_reenter", ev(ST_ACTIVE, 0, 1, 0, 16'h0700, 0));
    set_pc(16'hE0FF); tick2("at_max0", ev(ST_ACTIVE, 0, 1, 0, 16'h0700, 0));
    set_pc(16'hF000); tick2("exit_idle", ev(ST_IDLE, 0, 0, 0, 16'h0700, 0));

    // Overlap: region 1 now starts inside region 0; lowest index wins.
    ucc_min[31:16] = 16'hE080;
    set_pc(16'hE080); tick2("overlap", ev(ST_VIOL, 1, 0, 0, 16'h0, 1));
    for (int i = 0; i < 3; i++) tick2("ovl_hold", ev(ST_VIOL, 1, 0, 0, 16'h0, 1));
    tick2("ovl_done", ev(ST_IDLE, 0, 0, 0, 16'h0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ucca_multi_region_monitor.md
UCCA_MULTI_REGION_MONITOR -- requirements
Module: ucca_multi_region_monitor

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 4: number of independently configured UCC regions (1..8).
REQ-002 SHALL have parameter ADDR_W, default 16: width of pc, addresses, bounds and stack pointer.
REQ-003 SHALL have parameter IRQ_MODE, default 0: 0 = interrupt inside a region is a violation; 1 = interrupt suspends the region.
REQ-004 SHALL have parameter RESET_HOLD, default 4: cycles `reset` stays asserted per violation (1..15).
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port system_reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pc, input, ADDR_W: current program counter.
REQ-008 SHALL have port inst_changed, input, 1: pc holds a new instruction this cycle.
REQ-009 SHALL have ports data_en and data_wr, input, 1 each: memory access strobe and write qualifier.
REQ-010 SHALL have port data_addr, input, ADDR_W: data access address.
REQ-011 SHALL have port stack_pointer, input, ADDR_W: current SP.
REQ-012 SHALL have port irq_jmp, input, 1: CPU taking an interrupt vector this cycle.
REQ-013 SHALL have ports ucc_min and ucc_max, input, NUM_REGIONS*ADDR_W each: packed bounds; region k occupies slice k.
REQ-014 SHALL have port region_en, input, NUM_REGIONS: per-region enable.
REQ-015 SHALL have outputs reset (1), in_region (1), active_region (clog2(NUM_REGIONS), min 1), base_pointer (ADDR_W) and viol_cause (3).

Function
REQ-016 Region k SHALL be valid only when region_en[k]=1 and ucc_min_k <= ucc_max_k; "pc in k" means ucc_min_k <= pc <= ucc_max_k, inclusive.
REQ-017 Overlapping valid regions SHALL resolve to the lowest index.
REQ-018 FSM states SHALL be IDLE, ACTIVE, SUSPENDED and VIOL; pc-based transitions SHALL be evaluated only on cycles with inst_changed=1.
REQ-019 A register prev_pc SHALL capture pc on every inst_changed cycle.
REQ-020 In IDLE, pc == ucc_min_k SHALL move to ACTIVE with active_region<=k and base_pointer<=stack_pointer.
REQ-021 In IDLE, pc inside region k but not equal to ucc_min_k SHALL move to VIOL with cause 1 (ENTRY).
REQ-022 In ACTIVE, data_en & data_wr & data_addr >= base_pointer SHALL move to VIOL with cause 3 (STACK), checked every cycle.
REQ-023 In ACTIVE, irq_jmp SHALL move to VIOL with cause 4 (IRQ) when IRQ_MODE=0, and to SUSPENDED when IRQ_MODE=1.
REQ-024 In ACTIVE, pc leaving region active_region with prev_pc == ucc_max of that region SHALL be a legal exit.
REQ-025 After a legal exit, the FSM SHALL go to IDLE, or directly to ACTIVE (new index, new base_pointer) if pc == ucc_min_j.
REQ-026 In ACTIVE, any other departure from the region SHALL move to VIOL with cause 2 (EXIT).
REQ-027 SUSPENDED SHALL perform no stack check.
REQ-028 In SUSPENDED, pc back inside region active_region SHALL resume ACTIVE with base_pointer unchanged.
REQ-029 In SUSPENDED, pc inside any other valid region SHALL move to VIOL with cause 5 (NEST).
REQ-030 Simultaneous events SHALL resolve by priority STACK > IRQ > EXIT > NEST > ENTRY; the highest cause is recorded.
REQ-031 `reset` SHALL be registered: asserted the cycle after detection and held for exactly RESET_HOLD cycles by a down-counter.
REQ-032 VIOL SHALL return to IDLE after RESET_HOLD cycles, with in_region=0 and base_pointer cleared to 0.
REQ-033 Events during VIOL SHALL be ignored; the counter SHALL NOT restart.
REQ-034 viol_cause SHALL be sticky until the next violation or system_reset_n.
REQ-035 in_region SHALL be 1 in ACTIVE and SUSPENDED only.
REQ-036 Region bounds or region_en changing while ACTIVE SHALL take effect on the next comparison, with no special handling.

Reset
REQ-037 system_reset_n=0 SHALL asynchronously force IDLE and set reset, in_region, active_region, base_pointer, viol_cause, prev_pc and the hold counter to 0.
REQ-038 Reset deasserted mid-violation SHALL restart in IDLE with reset=0 on the first clock edge.

Structure
REQ-039 State encoding and cause codes (NONE=0, ENTRY=1, EXIT=2, STACK=3, IRQ=4, NEST=5) SHALL live in shared package ucca_pkg.
REQ-040 Per-region comparison SHALL be sub-module ucca_region_match: outputs valid, in_range and at_entry from min, max, enable and pc; generated NUM_REGIONS times.

Verification
REQ-041 Region0 0xE000-0xE0FF: pc 0xE000 with SP 0x0400 -> in_region=1, active_region=0, base_pointer=0x0400; exit from prev_pc 0xE0FF to 0xC000 -> IDLE, reset stays 0.
REQ-042 IDLE, pc jumps to 0xE010 -> reset=1 for 4 cycles starting the next cycle, viol_cause=1.
REQ-043 ACTIVE with base 0x0400: write to 0x0402 -> viol_cause=3; write to 0x03FE -> no violation.
REQ-044 IRQ_MODE=1: irq_jmp in ACTIVE, ISR at 0xF800, pc returns 0xE020 -> ACTIVE, base_pointer still 0x0400; with IRQ_MODE=0 -> viol_cause=4.
REQ-045 Write >= base and illegal exit in the same cycle -> viol_cause=3.
REQ-046 system_reset_n pulsed low mid-hold -> all outputs 0 immediately, and the next legal entry works.
